imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RV decode stage. It covers all base formats (I/S/B/U/J) at XLEN 32 or 64. It reports the decoded format and flags illegal opcodes. The block sits between instruction fetch and the register-read/ALU operand mux, behind a valid/ready elastic pipeline of configurable depth.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64; immediates are sign-extended to XLEN.
PIPE_DEPTH, 1, number of register stages (1..4); sets the latency in cycles.
CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  inst_code is valid this cycle
in_ready  output  1  block accepts inst_code this cycle
inst_code  input  32  raw instruction word
out_valid  output  1  imm_out/imm_fmt/imm_illegal are valid
out_ready  input  1  consumer accepts the output this cycle
imm_out  output  XLEN  sign-extended immediate
imm_fmt  output  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 7=ILLEGAL
imm_illegal  output  1  opcode not recognised
illegal_cnt  output  CNT_W  count of accepted illegal instructions, saturating

Behaviour:
- Decode on inst_code[6:0]:
  - I-format: 0000011, 0010011, 1100111, 1110011; 0011011 only when XLEN=64, else ILLEGAL.
  - S-format: 0100011. B-format: 1100011. U-format: 0110111, 0010111. J-format: 1101111.
  - NONE (imm 0, not illegal): 0110011, 0001111; 0111011 only when XLEN=64, else ILLEGAL.
  - Any other opcode: imm_fmt=7, imm_illegal=1, imm_out=0.
- Immediate assembly (inst = inst_code):
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - U = {inst[31:12], 12'b0}
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - All formats sign-extend from the top bit (inst[31]) to XLEN. No output bit is ever undriven or high-impedance.
- Pipeline:
  - PIPE_DEPTH stages, each holding a valid bit plus {imm, fmt, illegal}.
  - Decode is combinational in front of stage 0.
  - A stage loads when it is empty or the stage after it is emptying in the same cycle. The last stage empties when out_valid && out_ready.
  - in_ready = stage-0 load condition. The ready chain is combinational; no bubbles at full throughput.
  - Latency: an instruction accepted in cycle N appears with out_valid=1 in cycle N+PIPE_DEPTH when there is no backpressure.
  - Throughput: 1 instruction per cycle when out_ready=1.
  - Order is strictly preserved; no drops, no duplicates.
- Backpressure:
  - While out_valid=1 and out_ready=0, every output holds stable.
  - Once all PIPE_DEPTH stages are full, in_ready=0.
  - A simultaneous accept and emit in a full pipe is allowed: in_ready=1 when out_ready=1.
- Illegal counter:
  - Increments by 1 on each in_valid && in_ready with an illegal opcode.
  - Saturates at all-ones; no wrap-around.
  - Counts at accept time, not emit time.
- Reset (async assert, sync release): all stage valid bits cleared, all data cleared, illegal_cnt=0.
  - Resulting outputs: out_valid=0, imm_out=0, imm_fmt=0, imm_illegal=0.
  - in_ready=1 from the first clock after deassert.
  - Reset mid-operation discards all in-flight instructions.
- Inputs while in_valid=0 are ignored; no state changes except emitting.

Test Plan:
- XLEN=64, PIPE_DEPTH=1, out_ready=1. Send 0xFFC12083 (lw x1,-4(x2)) -> next cycle out_valid=1, imm_fmt=1, imm_out=0xFFFFFFFFFFFFFFFC. Send 0xFE112E23 (sw x1,-4(x2)) -> imm_fmt=2, imm_out=0xFFFFFFFFFFFFFFFC.
- Send 0xFE000CE3 (beq x0,x0,-8) -> imm_fmt=3, imm_out=0xFFFFFFFFFFFFFFF8. Send 0x0010006F (jal x0,+2048) -> imm_fmt=5, imm_out=0x800.
- Send 0x800000B7 (lui x1,0x80000) -> imm_fmt=4, imm_out=0xFFFFFFFF80000000 at XLEN=64 and 0x80000000 at XLEN=32. Send 0x0000001B at XLEN=32 -> imm_illegal=1.
- PIPE_DEPTH=2, out_ready=0, present 3 back-to-back valid words -> 2 accepted, then in_ready=0, outputs frozen. Raise out_ready -> the 3 results emerge in order on consecutive cycles, with no loss or duplication.
- Send 0x0000007F three times -> imm_fmt=7, imm_out=0, illegal_cnt=3. With CNT_W=2, send 5 illegal words -> illegal_cnt stays at 3.
- Assert rst_n=0 with 2 instructions in flight -> out_valid=0 and illegal_cnt=0 immediately (async). After release, in_ready=1 and no stale outputs appear.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RV immediate generator: combinational I/S/B/U/J decode feeding an elastic
// valid/ready pipeline of PIPE_DEPTH stages, plus a saturating illegal-opcode counter.
module imm_gen_pipe #(
    parameter int XLEN       = 64,
    parameter int PIPE_DEPTH = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_fmt,
    output logic             imm_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_ILL  = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } stage_t;

    stage_t             dec;
    logic signed [31:0] imm32;

    always_comb begin
        dec   = '0;
        imm32 = '0;
        case (inst_code[6:0])
            7'b0000011, 7'b0010011,
            7'b1100111, 7'b1110011: dec.fmt = FMT_I;
            7'b0011011:             dec.fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
            7'b0100011:             dec.fmt = FMT_S;
            7'b1100011:             dec.fmt = FMT_B;
            7'b0110111, 7'b0010111: dec.fmt = FMT_U;
            7'b1101111:             dec.fmt = FMT_J;
            7'b0110011, 7'b0001111: dec.fmt = FMT_NONE;
            7'b0111011:             dec.fmt = (XLEN == 64) ? FMT_NONE : FMT_ILL;
            default:                dec.fmt = FMT_ILL;
        endcase
        // Assemble as a signed 32-bit value; the size cast below sign-extends to XLEN.
        case (dec.fmt)
            FMT_I:   imm32 = {{20{inst_code[31]}}, inst_code[31:20]};
            FMT_S:   imm32 = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
            FMT_B:   imm32 = {{19{inst_code[31]}}, inst_code[31], inst_code[7],
                              inst_code[30:25], inst_code[11:8], 1'b0};
            FMT_U:   imm32 = {inst_code[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                              inst_code[20], inst_code[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        dec.imm     = XLEN'(imm32);
        dec.illegal = (dec.fmt == FMT_ILL);
    end

    logic   [PIPE_DEPTH-1:0] vld_q, vld_d;
    stage_t [PIPE_DEPTH-1:0] stg_q, stg_d;
    logic   [PIPE_DEPTH:0]   rdy;
    logic   [PIPE_DEPTH:0]   src_v;
    stage_t [PIPE_DEPTH:0]   src;

    // A stage can take new data if it is empty or everything downstream drains.
    always_comb begin
        rdy             = '0;
        rdy[PIPE_DEPTH] = out_ready;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !vld_q[i] || rdy[i+1];
        end
    end

    always_comb begin
        src_v    = '0;
        src      = '0;
        src_v[0] = in_valid;
        src[0]   = dec;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            src_v[i+1] = vld_q[i];
            src[i+1]   = stg_q[i];
        end
        vld_d = vld_q;
        stg_d = stg_q;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (rdy[i]) begin
                vld_d[i] = src_v[i];
                if (src_v[i]) stg_d[i] = src[i];
            end
        end
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && rdy[0] && dec.illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            stg_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            stg_q <= stg_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready    = rdy[0];
    assign out_valid   = vld_q[PIPE_DEPTH-1];
    assign imm_out     = stg_q[PIPE_DEPTH-1].imm;
    assign imm_fmt     = stg_q[PIPE_DEPTH-1].fmt;
    assign imm_illegal = stg_q[PIPE_DEPTH-1].illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: instance A (XLEN=64, depth 2) and instance B (XLEN=32,
// depth 1, 2-bit counter); vector table, backpressure/reset sequences, random scoreboard.
module tb_imm_gen_pipe;

    localparam int A_D = 2;
    localparam int B_D = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_imm_illegal;
    logic [31:0] a_inst = '0;
    logic [63:0] a_imm_out;
    logic [2:0]  a_imm_fmt;
    logic [15:0] a_illegal_cnt;

    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_imm_illegal;
    logic [31:0] b_inst = '0;
    logic [31:0] b_imm_out;
    logic [2:0]  b_imm_fmt;
    logic [1:0]  b_illegal_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .PIPE_DEPTH(A_D), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .inst_code(a_inst), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .imm_out(a_imm_out), .imm_fmt(a_imm_fmt), .imm_illegal(a_imm_illegal),
        .illegal_cnt(a_illegal_cnt));

    imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(B_D), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .inst_code(b_inst), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .imm_out(b_imm_out), .imm_fmt(b_imm_fmt), .imm_illegal(b_imm_illegal),
        .illegal_cnt(b_illegal_cnt));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference decode from the ISA field rules, using integer arithmetic (XLEN=64).
    function automatic void ref_dec(input logic [31:0] in, output logic [63:0] imm,
                                    output logic [2:0] fmt);
        longint v;
        case (in[6:0])
            7'h03, 7'h13, 7'h67, 7'h73, 7'h1B: fmt = 1;
            7'h23: fmt = 2;
            7'h63: fmt = 3;
            7'h37, 7'h17: fmt = 4;
            7'h6F: fmt = 5;
            7'h33, 7'h0F, 7'h3B: fmt = 0;
            default: fmt = 7;
        endcase
        case (fmt)
            1: v = longint'(in[31:20]) - (in[31] ? 64'sd4096 : 64'sd0);
            2: v = longint'({in[31:25], in[11:7]}) - (in[31] ? 64'sd4096 : 64'sd0);
            3: v = longint'(in[7]) * 2048 + longint'(in[30:25]) * 32
                   + longint'(in[11:8]) * 2 - (in[31] ? 64'sd4096 : 64'sd0);
            4: v = (longint'(in[31:12]) - (in[31] ? 64'sd1048576 : 64'sd0)) * 4096;
            5: v = longint'(in[19:12]) * 4096 + longint'(in[20]) * 2048
                   + longint'(in[30:21]) * 2 - (in[31] ? 64'sd1048576 : 64'sd0);
            default: v = 0;
        endcase
        imm = v;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] op;
        logic [31:0] r;
        case ($urandom_range(0, 15))
            0: op = 7'h03;  1: op = 7'h13;  2: op = 7'h67;  3: op = 7'h73;
            4: op = 7'h1B;  5: op = 7'h23;  6: op = 7'h63;  7: op = 7'h37;
            8: op = 7'h17;  9: op = 7'h6F;  10: op = 7'h33; 11: op = 7'h0F;
            12: op = 7'h3B; 13: op = 7'h7F; 14: op = 7'h00;
            default: op = 7'($urandom);
        endcase
        r = $urandom;
        return {r[31:7], op};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        a_in_valid = 0; b_in_valid = 0; a_out_ready = 0; b_out_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Send one word into an empty pipe with out_ready=1 and check latency and result.
    task automatic run_vec(input bit sel, input logic [31:0] inst, input logic [2:0] efmt,
                           input logic [63:0] eimm, input string nm);
        int cyc;
        logic v;
        @(negedge clk);
        a_out_ready = 1; b_out_ready = 1;
        if (sel) begin b_in_valid = 1; b_inst = inst; end
        else     begin a_in_valid = 1; a_inst = inst; end
        @(posedge clk); #1;
        a_in_valid = 0; b_in_valid = 0;
        cyc = 1;
        v = sel ? b_out_valid : a_out_valid;
        while (!v && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            v = sel ? b_out_valid : a_out_valid;
        end
        chk({nm, "_lat"}, 64'(cyc), sel ? 64'(B_D) : 64'(A_D));
        if (sel) begin
            chk({nm, "_fmt"}, 64'(b_imm_fmt), 64'(efmt));
            chk({nm, "_imm"}, 64'(b_imm_out), eimm);
            chk({nm, "_ill"}, 64'(b_imm_illegal), 64'(efmt == 3'd7));
        end else begin
            chk({nm, "_fmt"}, 64'(a_imm_fmt), 64'(efmt));
            chk({nm, "_imm"}, a_imm_out, eimm);
            chk({nm, "_ill"}, 64'(a_imm_illegal), 64'(efmt == 3'd7));
        end
        @(posedge clk);
    endtask

    typedef struct {
        bit          sel;
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [63:0] imm;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    vec_t vecs[16];

    initial begin
        exp_t q[$];
        exp_t e;
        logic [15:0] mcnt;
        logic        stall_prev;
        logic [63:0] imm_prev;
        logic [2:0]  fmt_prev;

        vecs[0]  = '{0, 32'hFFC12083, 3'd1, 64'hFFFFFFFFFFFFFFFC};
        vecs[1]  = '{0, 32'hFE112E23, 3'd2, 64'hFFFFFFFFFFFFFFFC};
        vecs[2]  = '{0, 32'hFE000CE3, 3'd3, 64'hFFFFFFFFFFFFFFF8};
        vecs[3]  = '{0, 32'h0010006F, 3'd5, 64'h0000000000000800};
        vecs[4]  = '{0, 32'h800000B7, 3'd4, 64'hFFFFFFFF80000000};
        vecs[5]  = '{0, 32'h0000001B, 3'd1, 64'h0};
        vecs[6]  = '{0, 32'h0000003B, 3'd0, 64'h0};
        vecs[7]  = '{0, 32'h00000033, 3'd0, 64'h0};
        vecs[8]  = '{0, 32'h0000007F, 3'd7, 64'h0};
        vecs[9]  = '{0, 32'h7FF00013, 3'd1, 64'h00000000000007FF};
        vecs[10] = '{0, 32'h12345017, 3'd4, 64'h0000000012345000};
        vecs[11] = '{1, 32'h800000B7, 3'd4, 64'h0000000080000000};
        vecs[12] = '{1, 32'h0000001B, 3'd7, 64'h0};
        vecs[13] = '{1, 32'h0000003B, 3'd7, 64'h0};
        vecs[14] = '{1, 32'hFFC12083, 3'd1, 64'h00000000FFFFFFFC};
        vecs[15] = '{1, 32'h0010006F, 3'd5, 64'h0000000000000800};

        // Reset state
        #2;
        chk("rst_a_valid", 64'(a_out_valid), 0);
        chk("rst_a_imm", a_imm_out, 0);
        chk("rst_a_fmt", 64'(a_imm_fmt), 0);
        chk("rst_a_ill", 64'(a_imm_illegal), 0);
        chk("rst_a_cnt", 64'(a_illegal_cnt), 0);
        chk("rst_b_valid", 64'(b_out_valid), 0);
        chk("rst_b_imm", 64'(b_imm_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); @(negedge clk); #1;
        chk("post_rst_in_ready", 64'(a_in_ready), 1);

        for (int i = 0; i < 16; i++) run_vec(vecs[i].sel, vecs[i].inst, vecs[i].fmt, vecs[i].imm,
                                             $sformatf("vec%0d", i));

        // Backpressure on depth-2 pipe: two accepted, third held, then drained in order
        @(negedge clk);
        a_out_ready = 0; a_in_valid = 1; a_inst = 32'hFFC12083; #1;
        chk("bp_rdy0", 64'(a_in_ready), 1);
        @(negedge clk);
        a_inst = 32'h0010006F; #1;
        chk("bp_rdy1", 64'(a_in_ready), 1);
        @(negedge clk);
        a_inst = 32'h800000B7; #1;
        chk("bp_full_rdy", 64'(a_in_ready), 0);
        chk("bp_full_valid", 64'(a_out_valid), 1);
        chk("bp_full_imm", a_imm_out, 64'hFFFFFFFFFFFFFFFC);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_hold_rdy", 64'(a_in_ready), 0);
        chk("bp_hold_imm", a_imm_out, 64'hFFFFFFFFFFFFFFFC);
        chk("bp_hold_fmt", 64'(a_imm_fmt), 1);
        @(negedge clk);
        a_out_ready = 1; #1;
        chk("bp_pass_rdy", 64'(a_in_ready), 1);
        chk("bp_out0_imm", a_imm_out, 64'hFFFFFFFFFFFFFFFC);
        @(negedge clk);
        a_in_valid = 0; #1;
        chk("bp_out1_valid", 64'(a_out_valid), 1);
        chk("bp_out1_fmt", 64'(a_imm_fmt), 5);
        chk("bp_out1_imm", a_imm_out, 64'h800);
        @(negedge clk); #1;
        chk("bp_out2_valid", 64'(a_out_valid), 1);
        chk("bp_out2_fmt", 64'(a_imm_fmt), 4);
        chk("bp_out2_imm", a_imm_out, 64'hFFFFFFFF80000000);
        @(negedge clk); #1;
        chk("bp_nodup", 64'(a_out_valid), 0);

        // Illegal counter
        do_reset();
        for (int i = 0; i < 3; i++) run_vec(0, 32'h0000007F, 3'd7, 64'h0, "cnt_a");
        chk("cnt_a_3", 64'(a_illegal_cnt), 3);
        do_reset();
        for (int i = 0; i < 5; i++) run_vec(1, 32'h0000007F, 3'd7, 64'h0, "cnt_b");
        chk("cnt_b_sat", 64'(b_illegal_cnt), 3);

        // Reset with two instructions in flight
        do_reset();
        @(negedge clk);
        a_out_ready = 0; a_in_valid = 1; a_inst = 32'h0000007F;
        @(negedge clk);
        a_inst = 32'h00000000;
        @(negedge clk);
        a_in_valid = 0; #1;
        chk("mid_cnt_pre", 64'(a_illegal_cnt), 2);
        chk("mid_valid_pre", 64'(a_out_valid), 1);
        rst_n = 0; #1;
        chk("mid_rst_valid", 64'(a_out_valid), 0);
        chk("mid_rst_cnt", 64'(a_illegal_cnt), 0);
        chk("mid_rst_fmt", 64'(a_imm_fmt), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk); #1;
        chk("mid_rel_rdy", 64'(a_in_ready), 1);
        a_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("mid_no_stale", 64'(a_out_valid), 0);
        end

        // Random traffic on A against the reference model
        do_reset();
        mcnt = 0;
        stall_prev = 0;
        imm_prev = '0;
        fmt_prev = '0;
        for (int c = 0; c < 600; c++) begin
            logic [63:0] ri;
            logic [2:0]  rf;
            @(negedge clk);
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_inst      = rand_inst();
            a_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_cnt", 64'(a_illegal_cnt), 64'(mcnt));
            chk("rnd_in_ready", 64'(a_in_ready), 64'((q.size() < A_D) || a_out_ready));
            if (stall_prev) begin
                chk("rnd_hold_valid", 64'(a_out_valid), 1);
                chk("rnd_hold_imm", a_imm_out, imm_prev);
                chk("rnd_hold_fmt", 64'(a_imm_fmt), 64'(fmt_prev));
            end
            if (a_out_valid && a_out_ready) begin
                if (q.size() == 0) chk("rnd_spurious", 64'(a_out_valid), 0);
                else begin
                    e = q.pop_front();
                    chk("rnd_imm", a_imm_out, e.imm);
                    chk("rnd_fmt", 64'(a_imm_fmt), 64'(e.fmt));
                    chk("rnd_ill", 64'(a_imm_illegal), 64'(e.fmt == 3'd7));
                end
            end
            stall_prev = a_out_valid && !a_out_ready;
            imm_prev = a_imm_out;
            fmt_prev = a_imm_fmt;
            if (a_in_valid && a_in_ready) begin
                ref_dec(a_inst, ri, rf);
                q.push_back('{ri, rf});
                if (rf == 3'd7 && mcnt != 16'hFFFF) mcnt++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a_in_valid = 0; a_out_ready = 1; #1;
            if (a_out_valid) begin
                if (q.size() == 0) chk("drain_spurious", 64'(a_out_valid), 0);
                else begin
                    e = q.pop_front();
                    chk("drain_imm", a_imm_out, e.imm);
                    chk("drain_fmt", 64'(a_imm_fmt), 64'(e.fmt));
                end
            end
        end
        chk("drain_empty", 64'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
